// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared CAN 2.0A constants, state encodings and field helpers
package can_pkg;

  // Receive FSM state encodings
  typedef logic [3:0] can_state_t;
  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_ID      = 4'd1;
  localparam logic [3:0] ST_RTR     = 4'd2;
  localparam logic [3:0] ST_CTRL    = 4'd3;
  localparam logic [3:0] ST_DATA    = 4'd4;
  localparam logic [3:0] ST_CRC     = 4'd5;
  localparam logic [3:0] ST_CRC_DEL = 4'd6;
  localparam logic [3:0] ST_ACK     = 4'd7;
  localparam logic [3:0] ST_ACK_DEL = 4'd8;
  localparam logic [3:0] ST_EOF     = 4'd9;
  localparam logic [3:0] ST_ERR     = 4'd10;

  localparam logic [14:0] CRC15_POLY = 15'h4599;

  localparam logic [1:0] ERR_STUFF = 2'd1;
  localparam logic [1:0] ERR_FORM  = 2'd2;
  localparam logic [1:0] ERR_CRC   = 2'd3;

  localparam int ID_LEN   = 11;
  localparam int DLC_LEN  = 4;
  localparam int CRC_LEN  = 15;
  localparam int EOF_LEN  = 7;
  // IDE + r0 + DLC
  localparam int CTRL_LEN = 2 + DLC_LEN;

  // Unstuffing is applied from SOF through the last CRC bit only
  function automatic logic stuff_active(input logic [3:0] st);
    return (st == ST_IDLE) || (st == ST_ID) || (st == ST_RTR) ||
           (st == ST_CTRL) || (st == ST_DATA) || (st == ST_CRC);
  endfunction

  // Number of data-field bits: none for remote frames, DLC above the cap is clamped
  function automatic logic [6:0] data_bit_count(input logic rtr, input logic [3:0] dlc,
                                                input int max_bytes);
    int n;
    if (rtr) n = 0;
    else if (int'(dlc) > max_bytes) n = max_bytes;
    else n = int'(dlc);
    return 7'(n * 8);
  endfunction

endpackage

// File: rtl/can_crc15.sv
// rtl/can_crc15.sv - serial CRC-15 (CAN polynomial), one bit per enable
module can_crc15 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [14:0] rem
);
  import can_pkg::*;

  logic [14:0] base;
  logic [14:0] stepped;

  // A clear coinciding with an enable folds the new bit into an empty register
  always_comb begin
    base    = clr ? 15'd0 : rem;
    stepped = {base[13:0], 1'b0} ^ ((din ^ base[14]) ? CRC15_POLY : 15'd0);
  end

  // Remainder register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   rem <= 15'd0;
    else if (en)  rem <= stepped;
    else if (clr) rem <= 15'd0;
  end

endmodule

// File: rtl/can_frame_parser.sv
// rtl/can_frame_parser.sv - CAN 2.0A receive frame parser downstream of the unstuffer
module can_frame_parser #(
  parameter int IDLE_BITS = 3,
  parameter int MAX_BYTES = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   bit_valid,
  input  logic                   bit_in,
  input  logic                   stuff_err,
  output logic                   stuff_en,
  output logic                   frame_valid,
  output logic                   frame_err,
  output logic [1:0]             err_code,
  output logic [10:0]            frame_id,
  output logic                   frame_rtr,
  output logic [3:0]             frame_dlc,
  output logic [8*MAX_BYTES-1:0] frame_data
);
  import can_pkg::*;

  localparam int        DW       = 8 * MAX_BYTES;
  localparam int        IW       = $clog2(DW);
  localparam logic [7:0] IDLE_MAX = 8'(IDLE_BITS);

  logic [3:0]    state;
  logic [3:0]    state_nxt;
  logic [6:0]    bit_cnt;
  logic [7:0]    idle_cnt;
  logic [6:0]    data_bits;

  // Shadow copies of the fields, published only when the frame completes cleanly
  logic [10:0]   id_sh;
  logic          rtr_sh;
  logic [3:0]    dlc_sh;
  logic [DW-1:0] data_sh;

  logic          crc_clr;
  logic          crc_en;
  logic [14:0]   crc_rem;

  logic          sof;
  logic          last_bit;
  logic          stuff_hit;
  logic          form_hit;
  logic          crc_hit;
  logic          any_err;
  logic [3:0]    dlc_full;
  logic [IW-1:0] data_idx;

  // Field-end detection, error classification and next-state selection
  always_comb begin
    sof       = bit_valid && (state == ST_IDLE) && !bit_in && (idle_cnt >= IDLE_MAX);
    dlc_full  = {dlc_sh[2:0], bit_in};
    data_idx  = IW'(DW - 1) - IW'(bit_cnt);

    last_bit = 1'b0;
    case (state)
      ST_ID:   last_bit = (bit_cnt == 7'(ID_LEN - 1));
      ST_CTRL: last_bit = (bit_cnt == 7'(CTRL_LEN - 1));
      ST_DATA: last_bit = (bit_cnt == data_bits - 7'd1);
      ST_CRC:  last_bit = (bit_cnt == 7'(CRC_LEN - 1));
      ST_EOF:  last_bit = (bit_cnt == 7'(EOF_LEN - 1));
      default: last_bit = 1'b0;
    endcase

    stuff_hit = bit_valid && stuff_err && (state != ST_IDLE) && (state != ST_ERR);
    form_hit  = bit_valid && (((state == ST_CTRL) && (bit_cnt == 7'd0) && bit_in) ||
                              ((state == ST_CRC_DEL) && !bit_in) ||
                              ((state == ST_ACK_DEL) && !bit_in) ||
                              ((state == ST_EOF) && !bit_in));
    crc_hit   = bit_valid && (state == ST_CRC_DEL) && (crc_rem != 15'd0);
    any_err   = stuff_hit || form_hit || crc_hit;

    crc_clr = sof;
    crc_en  = sof || (bit_valid && ((state == ST_ID) || (state == ST_RTR) ||
                                    (state == ST_CTRL) || (state == ST_DATA) ||
                                    (state == ST_CRC)));

    state_nxt = state;
    if (bit_valid) begin
      if (any_err) begin
        state_nxt = ST_ERR;
      end else begin
        case (state)
          ST_IDLE:    if (sof) state_nxt = ST_ID;
          ST_ID:      if (last_bit) state_nxt = ST_RTR;
          ST_RTR:     state_nxt = ST_CTRL;
          ST_CTRL:    if (last_bit)
                        state_nxt = (data_bit_count(rtr_sh, dlc_full, MAX_BYTES) == 7'd0) ?
                                    ST_CRC : ST_DATA;
          ST_DATA:    if (last_bit) state_nxt = ST_CRC;
          ST_CRC:     if (last_bit) state_nxt = ST_CRC_DEL;
          ST_CRC_DEL: state_nxt = ST_ACK;
          ST_ACK:     state_nxt = ST_ACK_DEL;
          ST_ACK_DEL: state_nxt = ST_EOF;
          ST_EOF:     if (last_bit) state_nxt = ST_IDLE;
          ST_ERR:     if (bit_in && ((idle_cnt + 8'd1) >= IDLE_MAX)) state_nxt = ST_IDLE;
          default:    state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  can_crc15 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (bit_in),
    .rem   (crc_rem)
  );

  // Frame walk: state, bit counter, shadow capture and registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= 7'd0;
      idle_cnt    <= 8'd0;
      data_bits   <= 7'd0;
      id_sh       <= 11'd0;
      rtr_sh      <= 1'b0;
      dlc_sh      <= 4'd0;
      data_sh     <= '0;
      stuff_en    <= 1'b1;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'd0;
      frame_id    <= 11'd0;
      frame_rtr   <= 1'b0;
      frame_dlc   <= 4'd0;
      frame_data  <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      state       <= state_nxt;
      stuff_en    <= stuff_active(state_nxt);

      if (state_nxt != state) bit_cnt <= 7'd0;
      else if (bit_valid)     bit_cnt <= bit_cnt + 7'd1;

      if (bit_valid) begin
        if (any_err) begin
          frame_err <= 1'b1;
          err_code  <= stuff_hit ? ERR_STUFF : (form_hit ? ERR_FORM : ERR_CRC);
          idle_cnt  <= 8'd0;
        end else begin
          case (state)
            ST_IDLE: begin
              if (bit_in) begin
                if (idle_cnt < IDLE_MAX) idle_cnt <= idle_cnt + 8'd1;
              end else begin
                idle_cnt <= 8'd0;
                if (sof) begin
                  id_sh   <= 11'd0;
                  rtr_sh  <= 1'b0;
                  dlc_sh  <= 4'd0;
                  data_sh <= '0;
                end
              end
            end
            ST_ID:   id_sh  <= {id_sh[ID_LEN-2:0], bit_in};
            ST_RTR:  rtr_sh <= bit_in;
            ST_CTRL: begin
              if (bit_cnt >= 7'd2) dlc_sh <= dlc_full;
              if (last_bit) data_bits <= data_bit_count(rtr_sh, dlc_full, MAX_BYTES);
            end
            ST_DATA: data_sh[data_idx] <= bit_in;
            ST_EOF: begin
              if (last_bit) begin
                frame_valid <= 1'b1;
                frame_id    <= id_sh;
                frame_rtr   <= rtr_sh;
                frame_dlc   <= dlc_sh;
                frame_data  <= data_sh;
                idle_cnt    <= 8'd0;
              end
            end
            ST_ERR: begin
              if (!bit_in)                   idle_cnt <= 8'd0;
              else if (state_nxt == ST_IDLE) idle_cnt <= 8'd0;
              else                           idle_cnt <= idle_cnt + 8'd1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_can_frame_parser.sv
// tb/tb_can_frame_parser.sv - directed self-checking bench for can_frame_parser
module tb_can_frame_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_in = 1'b1;
  logic        stuff_err = 1'b0;
  logic        stuff_en;
  logic        frame_valid;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [10:0] frame_id;
  logic        frame_rtr;
  logic [3:0]  frame_dlc;
  logic [63:0] frame_data;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_err = 0;
  int gap = 0;
  logic fb[$];

  always #5 clk = ~clk;

  can_frame_parser #(.IDLE_BITS(3), .MAX_BYTES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .stuff_err   (stuff_err),
    .stuff_en    (stuff_en),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .err_code    (err_code),
    .frame_id    (frame_id),
    .frame_rtr   (frame_rtr),
    .frame_dlc   (frame_dlc),
    .frame_data  (frame_data)
  );

  // Pulse counters sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (frame_valid) n_valid++;
    if (frame_err)   n_err++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic se);
    bit_valid = 1'b1;
    bit_in    = b;
    stuff_err = se;
    @(negedge clk);
    bit_valid = 1'b0;
    stuff_err = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_idle(input int k);
    for (int i = 0; i < k; i++) send_bit(1'b1, 1'b0);
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_bit(fb[i], 1'b0);
  endtask

  // Unstuffed frame image with CRC-15 computed by a bitwise reference model
  task automatic build(input logic [10:0] id, input logic rtr, input logic ide,
                       input logic [3:0] dlc, input logic [63:0] data, input int nbytes);
    logic [14:0] crc;
    logic        nx;
    fb.delete();
    fb.push_back(1'b0);
    for (int i = 10; i >= 0; i--) fb.push_back(id[i]);
    fb.push_back(rtr);
    fb.push_back(ide);
    fb.push_back(1'b0);
    for (int i = 3; i >= 0; i--) fb.push_back(dlc[i]);
    for (int i = 0; i < nbytes * 8; i++) fb.push_back(data[63 - i]);
    crc = 15'd0;
    foreach (fb[i]) begin
      nx  = fb[i] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (nx) crc = crc ^ 15'h4599;
    end
    for (int i = 14; i >= 0; i--) fb.push_back(crc[i]);
    fb.push_back(1'b1);
    fb.push_back(1'b0);
    fb.push_back(1'b1);
    for (int i = 0; i < 7; i++) fb.push_back(1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_stuff_en"}, 64'(stuff_en), 64'd1);
    check({tag, "_valid"},    64'(frame_valid), 64'd0);
    check({tag, "_err"},      64'(frame_err), 64'd0);
    check({tag, "_code"},     64'(err_code), 64'd0);
    check({tag, "_id"},       64'(frame_id), 64'd0);
    check({tag, "_rtr"},      64'(frame_rtr), 64'd0);
    check({tag, "_dlc"},      64'(frame_dlc), 64'd0);
    check({tag, "_data"},     frame_data, 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Good frame, back-to-back strobes
    gap = 0;
    build(11'h123, 1'b0, 1'b0, 4'd2, 64'hABCD000000000000, 2);
    send_idle(3);
    send_range(0, fb.size() - 12);
    check("f1_stuff_en_crc", 64'(stuff_en), 64'd1);
    send_range(fb.size() - 11, fb.size() - 11);
    check("f1_stuff_en_crcdel", 64'(stuff_en), 64'd0);
    send_range(fb.size() - 10, fb.size() - 1);
    check("f1_nvalid", 64'(n_valid), 64'd1);
    check("f1_nerr",   64'(n_err), 64'd0);
    check("f1_id",     64'(frame_id), 64'h123);
    check("f1_rtr",    64'(frame_rtr), 64'd0);
    check("f1_dlc",    64'(frame_dlc), 64'd2);
    check("f1_data",   frame_data, 64'hABCD000000000000);
    check("f1_stuff_en_idle", 64'(stuff_en), 64'd1);

    // Same frame, one data bit flipped, spaced strobes
    gap = 1;
    build(11'h123, 1'b0, 1'b0, 4'd2, 64'hABCD000000000000, 2);
    fb[20] = ~fb[20];
    send_idle(3);
    send_range(0, fb.size() - 10);
    check("f2_nerr",   64'(n_err), 64'd1);
    check("f2_code",   64'(err_code), 64'd3);
    check("f2_nvalid", 64'(n_valid), 64'd1);
    check("f2_id",     64'(frame_id), 64'h123);
    check("f2_dlc",    64'(frame_dlc), 64'd2);
    check("f2_data",   frame_data, 64'hABCD000000000000);
    check("f2_stuff_en_err", 64'(stuff_en), 64'd0);
    send_idle(3);

    // Remote frame: no data phase
    gap = 0;
    build(11'h7FF, 1'b1, 1'b0, 4'd4, 64'd0, 0);
    send_idle(3);
    send_range(0, fb.size() - 1);
    check("f3_nvalid", 64'(n_valid), 64'd2);
    check("f3_id",     64'(frame_id), 64'h7FF);
    check("f3_rtr",    64'(frame_rtr), 64'd1);
    check("f3_dlc",    64'(frame_dlc), 64'd4);
    check("f3_data",   frame_data, 64'd0);

    // IDE=1 is a form error, then a too-early dominant is ignored
    build(11'h555, 1'b0, 1'b1, 4'd2, 64'd0, 0);
    send_idle(3);
    send_range(0, 13);
    check("f4_nerr", 64'(n_err), 64'd2);
    check("f4_code", 64'(err_code), 64'd2);
    send_idle(3);
    send_idle(2);
    send_bit(1'b0, 1'b0);
    build(11'h0F0, 1'b0, 1'b0, 4'd1, 64'h5A00000000000000, 1);
    send_idle(3);
    send_range(0, fb.size() - 1);
    check("f4b_nvalid", 64'(n_valid), 64'd3);
    check("f4b_nerr",   64'(n_err), 64'd2);
    check("f4b_id",     64'(frame_id), 64'h0F0);
    check("f4b_rtr",    64'(frame_rtr), 64'd0);
    check("f4b_dlc",    64'(frame_dlc), 64'd1);
    check("f4b_data",   frame_data, 64'h5A00000000000000);

    // Stuff error and bad CRC delimiter on the same strobe
    gap = 2;
    build(11'h321, 1'b0, 1'b0, 4'd1, 64'h1100000000000000, 1);
    send_idle(3);
    send_range(0, fb.size() - 11);
    send_bit(1'b0, 1'b1);
    check("f5_nerr",   64'(n_err), 64'd3);
    check("f5_code",   64'(err_code), 64'd1);
    check("f5_nvalid", 64'(n_valid), 64'd3);
    check("f5_id",     64'(frame_id), 64'h0F0);
    send_idle(3);

    // DLC above 8 carries 8 bytes and reports the raw DLC
    gap = 0;
    build(11'h456, 1'b0, 1'b0, 4'd12, 64'h0123456789ABCDEF, 8);
    send_idle(3);
    send_range(0, fb.size() - 1);
    check("f6_nvalid", 64'(n_valid), 64'd4);
    check("f6_id",     64'(frame_id), 64'h456);
    check("f6_dlc",    64'(frame_dlc), 64'd12);
    check("f6_data",   frame_data, 64'h0123456789ABCDEF);

    // Reset in the middle of DATA
    build(11'h2AA, 1'b0, 1'b0, 4'd3, 64'hDEADBE0000000000, 3);
    send_idle(3);
    send_range(0, 25);
    rst_n = 1'b0;
    #1;
    check_reset_values("mrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_nvalid", 64'(n_valid), 64'd4);
    check("mrst_nerr",   64'(n_err), 64'd3);
    send_idle(3);
    send_range(0, fb.size() - 1);
    check("f8_nvalid", 64'(n_valid), 64'd5);
    check("f8_nerr",   64'(n_err), 64'd3);
    check("f8_id",     64'(frame_id), 64'h2AA);
    check("f8_dlc",    64'(frame_dlc), 64'd3);
    check("f8_data",   frame_data, 64'hDEADBE0000000000);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
